seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised, run-time programmable serial bit-pattern detector. It is the successor to the team's fixed 4-bit Moore sequence detectors.
- It watches a 1-bit serial stream qualified by a valid strobe and matches a PAT_W-bit pattern. The pattern is loaded from configuration ports, so no RTL change is needed per pattern.
- Overlapping or non-overlapping detection is selectable at run time.
- It outputs a registered one-cycle Moore-style match flag and a saturating match counter for status/debug.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..32.
- CNT_W, 8, width of the saturating match counter; legal range 1..32.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- cfg_load, input, 1, latch cfg_pattern/cfg_overlap and flush history.
- cfg_pattern, input, PAT_W, pattern; MSB is the first bit received.
- cfg_overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping.
- in_valid, input, 1, in is a valid stream bit this cycle.
- in, input, 1, serial data bit.
- cnt_clr, input, 1, synchronous clear of match_cnt.
- q, output, 1, match flag; high for exactly one cycle per match.
- match_cnt, output, CNT_W, saturating count of matches.
- hist_full, output, 1, history holds PAT_W valid bits.

Behaviour:
- Reset (reset low, asynchronous) sets the following; all are held until reset deasserts:
  - q=0, match_cnt=0, hist_full=0;
  - internal history=0, fill=0;
  - pattern register = {PAT_W{1'b0}}, overlap register = 0.
- State registers:
  - hist[PAT_W-1:0]: shift register, newest bit in LSB.
  - fill: range 0..PAT_W, count of valid history bits.
  - pat_r and ovl_r: latched configuration.
- Priority each cycle: cfg_load > in_valid.
- cfg_load=1:
  - pat_r<=cfg_pattern, ovl_r<=cfg_overlap, fill<=0, hist<=0, q<=0.
  - Any in_valid bit in the same cycle is discarded.
  - match_cnt is unaffected.
- in_valid=1 and cfg_load=0:
  - hist_n = {hist[PAT_W-2:0], in}.
  - fill_n = min(fill+1, PAT_W).
  - match = (fill_n==PAT_W) && (hist_n==pat_r).
  - hist<=hist_n and q<=match.
  - On match with ovl_r=0: fill<=0, so the next bit starts a fresh search and no bit is reused.
  - On match with ovl_r=1: fill<=PAT_W, so the suffix is reused.
  - Without a match: fill<=fill_n.
- in_valid=0 and cfg_load=0: q<=0; hist and fill hold (gaps in the stream are transparent).
- Latency: q rises in the cycle immediately after the clk edge that sampled the final pattern bit. It is high for one cycle only.
  - Back-to-back overlapped matches give q high on consecutive valid cycles.
- hist_full = (fill==PAT_W); it is registered state, not a combinational comparison.
- match_cnt:
  - Increments by 1 on each cycle in which q is loaded with 1; saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr alone sets it to 0.
  - cnt_clr together with a match in the same cycle sets it to 1.
- Reset mid-stream: a partially received pattern is lost. After reset the stream is matched against the all-zero pattern until cfg_load is issued.
- Changing cfg_pattern or cfg_overlap without cfg_load has no effect.

Test Plan:
- Reset then cfg_load pattern 4'b1010, overlap=0; stream 1,0,1,0,1,0 on consecutive valid cycles -> q high only once, in the cycle after the 4th bit; match_cnt=1.
- Same stream with overlap=1 -> q high after bits 4 and 6; match_cnt=2.
- Pattern 1010, overlap=0; stream 1,0,1,1,0,1,0 with in_valid=0 gaps inserted between bits -> q high once, after the final 0; q=0 during every gap cycle.
- Pattern 4'b1111, overlap=1, CNT_W=2; ten consecutive 1s -> q high on bits 4..10 (7 pulses); match_cnt saturates at 3. Then cnt_clr alone -> 0; cnt_clr asserted on a match cycle -> 1.
- Pattern 1010 loaded; send 1,0,1; assert cfg_load (new pattern 0110) together with in_valid=1, in=0 -> no q. The subsequent stream 0,1,1,0 -> q after the 4th bit, proving the history flushed and the coincident bit was dropped.
- Assert reset asynchronously mid-pattern, between clock edges -> q, match_cnt and hist_full go 0 immediately. After release, stream 0,0,0,0 -> q high (default all-zero pattern).

Source files
------------

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_param
// Purpose  : Run-time programmable serial pattern detector with overlap select,
//            registered one-cycle match flag and saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             cfg_overlap,
   input  logic             in_valid,
   input  logic             in,
   input  logic             cnt_clr,
   output logic             q,
   output logic [CNT_W-1:0] match_cnt,
   output logic             hist_full
);

   localparam int                  c_FILL_W  = $clog2(PAT_W + 1);
   localparam logic [c_FILL_W-1:0] c_FULL    = c_FILL_W'(PAT_W);
   localparam logic [CNT_W-1:0]    c_CNT_MAX = '1;

   // Only the PAT_W-1 most recent bits need storing: the incoming bit
   // completes the PAT_W-wide comparison window.
   logic [PAT_W-2:0]    r_hist;
   logic [c_FILL_W-1:0] r_fill;
   logic [PAT_W-1:0]    r_pat;
   logic                r_ovl;
   logic                r_q;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_full;

   logic [PAT_W-1:0]    w_window;
   logic [c_FILL_W-1:0] w_fill_inc;
   logic                w_take;
   logic                w_match;
   logic [PAT_W-2:0]    w_hist_nxt;
   logic [c_FILL_W-1:0] w_fill_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;

   always_comb begin
      w_window   = {r_hist, in};
      w_fill_inc = (r_fill == c_FULL) ? c_FULL : r_fill + c_FILL_W'(1);
      w_take     = in_valid & ~cfg_load;
      w_match    = w_take && (w_fill_inc == c_FULL) && (w_window == r_pat);

      w_hist_nxt = r_hist;
      w_fill_nxt = r_fill;
      if (cfg_load) begin
         w_hist_nxt = '0;
         w_fill_nxt = '0;
      end else if (in_valid) begin
         w_hist_nxt = w_window[PAT_W-2:0];
         if (w_match)
            w_fill_nxt = r_ovl ? c_FULL : '0;
         else
            w_fill_nxt = w_fill_inc;
      end

      w_cnt_nxt = r_cnt;
      if (cnt_clr)
         w_cnt_nxt = CNT_W'(w_match);
      else if (w_match && (r_cnt != c_CNT_MAX))
         w_cnt_nxt = r_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hist <= '0;
         r_fill <= '0;
         r_pat  <= '0;
         r_ovl  <= 1'b0;
         r_q    <= 1'b0;
         r_cnt  <= '0;
         r_full <= 1'b0;
      end else begin
         if (cfg_load) begin
            r_pat <= cfg_pattern;
            r_ovl <= cfg_overlap;
         end
         r_hist <= w_hist_nxt;
         r_fill <= w_fill_nxt;
         r_q    <= w_match;
         r_cnt  <= w_cnt_nxt;
         r_full <= (w_fill_nxt == c_FULL);
      end
   end

   assign q         = r_q;
   assign match_cnt = r_cnt;
   assign hist_full = r_full;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_param
// Purpose  : Self-checking bench for seq_detect_param (PAT_W=4, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

   logic       clk;
   logic       reset;
   logic       cfg_load;
   logic [3:0] cfg_pattern;
   logic       cfg_overlap;
   logic       in_valid;
   logic       in;
   logic       cnt_clr;
   logic       q;
   logic [1:0] match_cnt;
   logic       hist_full;

   seq_detect_param #(.PAT_W(4), .CNT_W(2)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_overlap (cfg_overlap),
      .in_valid    (in_valid),
      .in          (in),
      .cnt_clr     (cnt_clr),
      .q           (q),
      .match_cnt   (match_cnt),
      .hist_full   (hist_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic [3:0] pat;
      logic       ovl;
      logic       v;
      logic       b;
      logic       clr;
      logic       eq;
      logic [1:0] ecnt;
      logic       efull;
   } vec_t;

   typedef struct {
      logic       eq;
      logic [1:0] ecnt;
      logic       efull;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(input logic ld, input logic [3:0] pat, input logic ovl,
                               input logic v, input logic b, input logic clr,
                               input logic eq, input logic [1:0] ecnt, input logic efull);
      vec_t r;
      r.ld = ld; r.pat = pat; r.ovl = ovl; r.v = v; r.b = b; r.clr = clr;
      r.eq = eq; r.ecnt = ecnt; r.efull = efull;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Non-load rows drive random configuration to show it is ignored without cfg_load.
   task automatic drive(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      cfg_load    = v.ld;
      cfg_pattern = v.ld ? v.pat : 4'($urandom);
      cfg_overlap = v.ld ? v.ovl : 1'($urandom);
      in_valid    = v.v;
      in          = v.v ? v.b : 1'($urandom);
      cnt_clr     = v.clr;
      e.eq = v.eq; e.ecnt = v.ecnt; e.efull = v.efull; e.tag = tag;
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, ".q"},    32'(q),         32'(e.eq));
         check({e.tag, ".cnt"},  32'(match_cnt), 32'(e.ecnt));
         check({e.tag, ".full"}, 32'(hist_full), 32'(e.efull));
      end
   end

   vec_t tbl[$];
   vec_t tail[$];

   initial begin
      reset = 1'b0; cfg_load = 1'b0; cfg_pattern = 4'h0; cfg_overlap = 1'b0;
      in_valid = 1'b0; in = 1'b0; cnt_clr = 1'b0;

      // ld pat ovl v b clr | q cnt full
      // non-overlap 1010 on 101010
      tbl.push_back(mk(1, 4'b1010, 0, 0, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2'd0, 0));
      // overlap 1010 on 101010
      tbl.push_back(mk(1, 4'b1010, 1, 0, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 2'd1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 2'd2, 1));
      // non-overlap 1010 on 1011010 with gaps
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2'd0, 1));
      tbl.push_back(mk(1, 4'b1010, 0, 0, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'd1, 0));
      // overlap 1111 on ten 1s, counter saturation and clear
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2'd0, 0));
      tbl.push_back(mk(1, 4'b1111, 1, 0, 0, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 2'd1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 2'd2, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 2'd3, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 2'd3, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 2'd3, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 2'd3, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 2'd3, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2'd0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 2'd1, 1));
      // reload with coincident valid bit dropped
      tbl.push_back(mk(1, 4'b1010, 0, 0, 0, 0, 0, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd1, 0));
      tbl.push_back(mk(1, 4'b0110, 0, 1, 0, 0, 0, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 2'd2, 0));
      // build up live state ahead of the asynchronous reset
      tbl.push_back(mk(1, 4'b1111, 1, 0, 0, 0, 0, 2'd2, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd2, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd2, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'd2, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 2'd3, 1));

      // after reset the pattern defaults to 0000, non-overlapping
      tail.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 0));
      tail.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 0));
      tail.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 0));
      tail.push_back(mk(0, 0, 0, 1, 0, 0, 1, 2'd1, 0));
      tail.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2'd1, 0));

      repeat (3) @(posedge clk);
      #1;
      check("rst.q",    32'(q),         32'd0);
      check("rst.cnt",  32'(match_cnt), 32'd0);
      check("rst.full", 32'(hist_full), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) drive(tbl[i], $sformatf("tbl%0d", i));

      // asynchronous reset between edges while q=1, cnt=3, full=1
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("arst.q",    32'(q),         32'd0);
      check("arst.cnt",  32'(match_cnt), 32'd0);
      check("arst.full", 32'(hist_full), 32'd0);
      @(negedge clk);
      cfg_load = 1'b0; in_valid = 1'b1; in = 1'b0; cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      check("arst_hold.q",   32'(q),         32'd0);
      check("arst_hold.cnt", 32'(match_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;

      foreach (tail[i]) drive(tail[i], $sformatf("post_rst%0d", i));

      @(negedge clk);
      in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
